dmem_responder: RTL and testbench

//   Data-memory side of the CPU<->DM interface: answers the pipeline's MEM-stage word

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Synthesizable data-memory responder: zero-latency word reads, byte-lane word writes and 256-bit block transfers.
// Optional `DMEM_STATS_EN adds saturating access counters (stat_word_rd, stat_word_wr, stat_blk).
//
//   state  | meaning
//   S_IDLE | no block transfer; accepts in-range dBlkWrite/dBlkRead
//   S_WAIT | latency countdown; block commit/load on the edge leaving it
//   S_RESP | one-cycle valid pulse, then back to idle
module dmem_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid,
  output logic         busy,
  output logic         addr_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]  stat_word_rd,
  output logic [15:0]  stat_word_wr,
  output logic [15:0]  stat_blk
`endif
);

  localparam int unsigned WORDS = 2 ** (ADDR_BITS - 2);
  localparam int unsigned CW = (BLK_LATENCY > 1) ? $clog2(BLK_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLK_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-6:0] blk_idx_q, blk_idx_d;
  logic                 blk_wr_q, blk_wr_d;
  logic [255:0]         blk_wdata_q, blk_wdata_d;
  logic [255:0]         blk_rdata_q, blk_rdata_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 blk_commit;

  logic [31:0]          mem [WORDS];
  logic [31:0]          off;
  logic                 in_range;
  logic [ADDR_BITS-3:0] widx;
  logic                 word_we;
  logic [2:0]           wr_n;
  logic [3:0]           wr_mask;
  logic [31:0]          wr_data;

  assign off      = data_address_2DM - BASE_ADDR;
  assign in_range = (off >> ADDR_BITS) == 32'd0;
  assign widx     = off[ADDR_BITS-1:2];
  assign word_we  = MemWrite_2DM && in_range;

  assign data_read_fDM = (MemRead_2DM && in_range) ? mem[widx] : 32'h0;
  assign addr_err = (MemRead_2DM || MemWrite_2DM || dBlkRead || dBlkWrite) && !in_range;

  // Big-endian lanes: source bytes go MSB-first from lane off[1:0]; overflow past lane 3 is dropped.
  always_comb begin
    wr_n    = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
    wr_mask = '0;
    wr_data = '0;
    for (int l = 0; l < 4; l++) begin
      if (3'(l) >= {1'b0, off[1:0]} && 3'(l) < ({1'b0, off[1:0]} + wr_n)) begin
        wr_mask[l] = 1'b1;
        wr_data[31-8*l -: 8] = data_write_2DM[8*(int'(wr_n) + int'(off[1:0]) - 1 - l) +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_idx_d   = blk_idx_q;
    blk_wr_d    = blk_wr_q;
    blk_wdata_d = blk_wdata_q;
    blk_rdata_d = blk_rdata_q;
    rd_valid_d  = 1'b0;
    wr_valid_d  = 1'b0;
    blk_commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((dBlkRead || dBlkWrite) && in_range) begin
          state_d     = S_WAIT;
          cnt_d       = CNT_LOAD;
          blk_idx_d   = off[ADDR_BITS-1:5];
          blk_wr_d    = dBlkWrite;
          blk_wdata_d = block_write_2DM;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (blk_wr_q) begin
            wr_valid_d = 1'b1;
            blk_commit = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            for (int i = 0; i < 8; i++) begin
              blk_rdata_d[255-32*i -: 32] = mem[{blk_idx_q, 3'(i)}];
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      blk_idx_q   <= '0;
      blk_wr_q    <= 1'b0;
      blk_wdata_q <= '0;
      blk_rdata_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_idx_q   <= blk_idx_d;
      blk_wr_q    <= blk_wr_d;
      blk_wdata_q <= blk_wdata_d;
      blk_rdata_q <= blk_rdata_d;
      rd_valid_q  <= rd_valid_d;
      wr_valid_q  <= wr_valid_d;
    end
  end

  // Block commit is written last so it overrides a same-edge word write to the same word.
  always_ff @(posedge CLK) begin
    if (word_we) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) mem[widx][31-8*l -: 8] <= wr_data[31-8*l -: 8];
      end
    end
    if (blk_commit) begin
      for (int i = 0; i < 8; i++) begin
        mem[{blk_idx_q, 3'(i)}] <= blk_wdata_q[255-32*i -: 32];
      end
    end
  end

  assign block_read_fDM        = blk_rdata_q;
  assign block_read_fDM_valid  = rd_valid_q;
  assign block_write_fDM_valid = wr_valid_q;
  assign busy                  = (state_q != S_IDLE);

`ifdef DMEM_STATS_EN
  logic [15:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d, st_blk_q, st_blk_d;

  always_comb begin
    st_rd_d  = st_rd_q;
    st_wr_d  = st_wr_q;
    st_blk_d = st_blk_q;
    if (MemRead_2DM && in_range && st_rd_q != 16'hFFFF) st_rd_d = st_rd_q + 16'd1;
    if (word_we && st_wr_q != 16'hFFFF) st_wr_d = st_wr_q + 16'd1;
    if ((rd_valid_d || wr_valid_d) && st_blk_q != 16'hFFFF) st_blk_d = st_blk_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_rd_q  <= '0;
      st_wr_q  <= '0;
      st_blk_q <= '0;
    end else begin
      st_rd_q  <= st_rd_d;
      st_wr_q  <= st_wr_d;
      st_blk_q <= st_blk_d;
    end
  end

  assign stat_word_rd = st_rd_q;
  assign stat_word_wr = st_wr_q;
  assign stat_blk     = st_blk_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations, then random traffic
// checked every cycle against a cycle-count based reference model of the store and block handshake.
module tb_dmem_responder;
  localparam int          AB   = 12;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          L    = 4;
  localparam int          NW   = 1 << (AB - 2);

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM, MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead, dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid, block_write_fDM_valid, busy, addr_err;
`ifdef DMEM_STATS_EN
  logic [15:0]  stat_word_rd, stat_word_wr, stat_blk;
`endif

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .BLK_LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET),
    .data_address_2DM(data_address_2DM), .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
    .data_write_2DM(data_write_2DM), .data_write_size_2DM(data_write_size_2DM),
    .data_read_fDM(data_read_fDM), .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
    .block_write_2DM(block_write_2DM), .block_read_fDM(block_read_fDM),
    .block_read_fDM_valid(block_read_fDM_valid), .block_write_fDM_valid(block_write_fDM_valid),
    .busy(busy), .addr_err(addr_err)
`ifdef DMEM_STATS_EN
    , .stat_word_rd(stat_word_rd), .stat_word_wr(stat_word_wr), .stat_blk(stat_blk)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit inr(input logic [31:0] a);
    return (a - BASE) < (32'd1 << AB);
  endfunction

  function automatic int widx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0]  m [NW];
  int           cyc = 0;
  bit           inflight = 0, resp = 0, blk_is_wr = 0, do_commit = 0;
  int           done_cyc = 0, blk_base = 0;
  logic [255:0] blk_wdata = '0, e_blk = '0;
  bit           e_rv = 0, e_wv = 0;
  int           s_rd = 0, s_wr = 0, s_blk = 0;

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int o, n, idx;
    idx = widx_of(a);
    o   = int'((a - BASE) % 4);
    n   = (sz == 2'd0) ? 4 : int'(sz);
    for (int j = 0; j < n; j++) begin
      if (o + j < 4) m[idx][31-8*(o+j) -: 8] = 8'((d >> (8 * (n - 1 - j))) & 32'hFF);
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    do_commit = 0;
    if (!RESET) begin
      inflight = 0; resp = 0; e_blk = '0; e_rv = 0; e_wv = 0;
      s_rd = 0; s_wr = 0; s_blk = 0;
    end else begin
      e_rv = 0; e_wv = 0;
      if (inflight && cyc == done_cyc) begin
        if (blk_is_wr) begin
          e_wv = 1; do_commit = 1;
        end else begin
          e_rv = 1;
          for (int i = 0; i < 8; i++) e_blk[255-32*i -: 32] = m[blk_base + i];
        end
        inflight = 0; resp = 1;
      end else if (resp) begin
        resp = 0;
      end else if (!inflight && (dBlkRead || dBlkWrite) && inr(data_address_2DM)) begin
        inflight  = 1;
        done_cyc  = cyc + L;
        blk_is_wr = dBlkWrite;
        blk_base  = int'((data_address_2DM - BASE) >> 5) * 8;
        blk_wdata = block_write_2DM;
      end
      if (MemRead_2DM && inr(data_address_2DM) && s_rd < 65535) s_rd++;
      if (MemWrite_2DM && inr(data_address_2DM) && s_wr < 65535) s_wr++;
      if ((e_rv || e_wv) && s_blk < 65535) s_blk++;
    end
    if (MemWrite_2DM && inr(data_address_2DM))
      model_write(data_address_2DM, data_write_2DM, data_write_size_2DM);
    if (do_commit)
      for (int i = 0; i < 8; i++) m[blk_base + i] = blk_wdata[255-32*i -: 32];
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] exp_rd;
  always @(negedge CLK) begin
    exp_rd = 32'h0;
    if (MemRead_2DM && inr(data_address_2DM)) exp_rd = m[widx_of(data_address_2DM)];
    chk("data_read_fDM", data_read_fDM, exp_rd);
    chk("addr_err", addr_err,
        (MemRead_2DM || MemWrite_2DM || dBlkRead || dBlkWrite) && !inr(data_address_2DM));
    if (!RESET) begin
      chk("busy_in_reset", busy, 1'b0);
      chk("rd_valid_in_reset", block_read_fDM_valid, 1'b0);
      chk("wr_valid_in_reset", block_write_fDM_valid, 1'b0);
      chk("block_read_in_reset", block_read_fDM, '0);
    end else begin
      chk("busy", busy, inflight || resp);
      chk("block_read_fDM_valid", block_read_fDM_valid, e_rv);
      chk("block_write_fDM_valid", block_write_fDM_valid, e_wv);
      chk("block_read_fDM", block_read_fDM, e_blk);
`ifdef DMEM_STATS_EN
      chk("stat_word_rd", stat_word_rd, 16'(s_rd));
      chk("stat_word_wr", stat_word_wr, 16'(s_wr));
      chk("stat_blk", stat_blk, 16'(s_blk));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic idle_inputs();
    MemRead_2DM = 0; MemWrite_2DM = 0; dBlkRead = 0; dBlkWrite = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    data_address_2DM = a; data_write_2DM = d; data_write_size_2DM = sz;
    MemRead_2DM = 0; MemWrite_2DM = 1;
    tick();
    MemWrite_2DM = 0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_address_2DM = a; MemRead_2DM = 1;
    @(negedge CLK);
    chk(name, data_read_fDM, exp);
    tick();
    MemRead_2DM = 0;
  endtask

  task automatic wait_valid(output int n, output bit rv, output bit wv, output int bc);
    n = 0; rv = 0; wv = 0; bc = 0;
    while (!rv && !wv && n < 50) begin
      tick();
      n++;
      rv = block_read_fDM_valid;
      wv = block_write_fDM_valid;
      if (!rv && !wv && busy) bc++;
    end
    checks++;
    if (!rv && !wv) begin
      errors++;
      $display("FAIL blk_timeout actual=no valid required=valid within 50 cycles");
    end
  endtask

  int           n, bc, hold;
  bit           rv, wv, seen, blk_active;
  logic [31:0]  blk_addr;
  logic [255:0] pat;
  logic [15:0]  st_before;

  initial begin
    RESET = 0; idle_inputs();
    data_address_2DM = 0; data_write_2DM = 0; data_write_size_2DM = 0; block_write_2DM = '0;
    st_before = 0; blk_active = 0; hold = 0; blk_addr = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_valid", block_read_fDM_valid, 1'b0);
    chk("rst_wr_valid", block_write_fDM_valid, 1'b0);
    chk("rst_block_read", block_read_fDM, '0);
    tick();
    RESET = 1;

    for (int i = 0; i < NW; i++) wr(BASE + 32'(4 * i), $urandom, 2'd0);

    // full-word write then read-back
    wr(32'h10, 32'hDEADBEEF, 2'd0);
    rd_chk("t1_word", 32'h10, 32'hDEADBEEF);

    // partial big-endian writes
    wr(32'h20, 32'h11223344, 2'd0);
    wr(32'h21, 32'h000000AA, 2'd1);
    rd_chk("t2_size1", 32'h20, 32'h11AA3344);
    wr(32'h23, 32'h00BBCCDD, 2'd3);
    rd_chk("t2_size3_drop", 32'h20, 32'h11AA33BB);

    // block read latency and word placement
    wr(32'h40, 32'hCAFEF00D, 2'd0);
    wr(32'h5C, 32'h76543210, 2'd0);
    data_address_2DM = 32'h44; dBlkRead = 1;
    wait_valid(n, rv, wv, bc);
    dBlkRead = 0;
    chk("t3_rd_valid", rv, 1'b1);
    chk("t3_latency", 32'(n - 1), 32'd4);
    chk("t3_busy_wait", 32'(bc), 32'd4);
    chk("t3_word0", block_read_fDM[255:224], 32'hCAFEF00D);
    chk("t3_word7", block_read_fDM[31:0], 32'h76543210);
    tick();

    // simultaneous write+read: write first, then read returns written block
    pat = 256'h0102030405060708_1112131415161718_2122232425262728_3132333435363738;
    data_address_2DM = 32'h80; block_write_2DM = pat; dBlkRead = 1; dBlkWrite = 1;
    wait_valid(n, rv, wv, bc);
    chk("t4_write_first", wv, 1'b1);
    chk("t4_no_read_first", rv, 1'b0);
    dBlkWrite = 0;
    wait_valid(n, rv, wv, bc);
    dBlkRead = 0;
    chk("t4_read_valid", rv, 1'b1);
    chk("t4_read_data", block_read_fDM, pat);
    tick();

    // reset during a block write aborts it
    wr(32'hC0, 32'h0BADF00D, 2'd0);
    data_address_2DM = 32'hC0; block_write_2DM = {8{32'h55AA55AA}}; dBlkWrite = 1;
    tick(); tick();
    RESET = 0; dBlkWrite = 0;
    @(negedge CLK);
    chk("t5_busy_rst", busy, 1'b0);
    tick(); tick();
    RESET = 1;
    seen = 0;
    repeat (8) begin tick(); seen |= block_write_fDM_valid; end
    chk("t5_no_valid", seen, 1'b0);
    rd_chk("t5_old_data", 32'hC0, 32'h0BADF00D);

    // out-of-range access: error flag, no read data, no commit, no block accept
    wr(32'h0, 32'h01234567, 2'd0);
`ifdef DMEM_STATS_EN
    st_before = stat_word_rd;
`endif
    data_address_2DM = BASE + 32'h1000; data_write_2DM = 32'hFFFFFFFF; data_write_size_2DM = 2'd0;
    MemRead_2DM = 1; MemWrite_2DM = 1; dBlkRead = 1;
    @(negedge CLK);
    chk("t6_addr_err", addr_err, 1'b1);
    chk("t6_read_zero", data_read_fDM, 32'h0);
    repeat (3) begin
      tick();
      @(negedge CLK);
      chk("t6_busy", busy, 1'b0);
    end
`ifdef DMEM_STATS_EN
    chk("t6_stat_rd", stat_word_rd, st_before);
`endif
    tick();
    idle_inputs();
    rd_chk("t6_no_alias", 32'h0, 32'h01234567);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        RESET = 0; idle_inputs(); blk_active = 0;
        tick(); tick();
        RESET = 1;
        continue;
      end
      if (blk_active) begin
        if (block_read_fDM_valid) dBlkRead = 0;
        if (block_write_fDM_valid) dBlkWrite = 0;
        hold++;
        if (!(dBlkRead || dBlkWrite) || hold > (inr(blk_addr) ? 40 : 6)) begin
          dBlkRead = 0; dBlkWrite = 0; blk_active = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: begin dBlkRead = 1; dBlkWrite = 0; end
          1: begin dBlkRead = 0; dBlkWrite = 1; end
          default: begin dBlkRead = 1; dBlkWrite = 1; end
        endcase
        blk_addr = ($urandom_range(0, 7) == 0) ? BASE + 32'h1000 + 32'($urandom_range(0, 255))
                                               : BASE + 32'($urandom_range(0, 4095));
        block_write_2DM = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
        hold = 0; blk_active = 1;
      end
      if (blk_active) begin
        data_address_2DM = inr(blk_addr) ? {blk_addr[31:5], 5'($urandom_range(0, 31))} : blk_addr;
      end else begin
        case ($urandom_range(0, 15))
          0: data_address_2DM = BASE + 32'h1000 + 32'($urandom_range(0, 63));
          1: data_address_2DM = 32'hFFFFFFFC;
          default: data_address_2DM = BASE + 32'($urandom_range(0, 4095));
        endcase
      end
      MemRead_2DM         = 1'($urandom_range(0, 1));
      MemWrite_2DM        = ($urandom_range(0, 2) == 0);
      data_write_2DM      = $urandom;
      data_write_size_2DM = 2'($urandom_range(0, 3));
    end
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
